row_window_ctrl: RTL

Parametrised successor to the fixed 3-row/4-word controller: sequences one frame of a K-row sliding-window convolution. It issues DRAM read addresses into the input FIFO and drains that FIFO into a ring of KERNEL+1 row register files. Each time a full KERNEL-row window is resident, it runs one psum pass (psum_en/first/last/head_addr) to the psum buffer. It then rotates the window base, while the spare buffer loads the next row in parallel.

---
 rtl/cnn_ctrl_pkg.sv | 33 +++
 rtl/row_loader.sv | 67 ++++++
 rtl/row_window_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types, derived sizes and helpers for the K-row sliding-window controller.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RUN  = 3'd2,
    ADV  = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

  localparam int unsigned DEF_KERNEL   = 32'd3;
  localparam int unsigned DEF_IMG_ROWS = 32'd6;
  localparam int unsigned NBUF         = DEF_KERNEL + 32'd1;
  localparam int unsigned OUT_ROWS     = DEF_IMG_ROWS - DEF_KERNEL + 32'd1;

  function automatic int unsigned nbuf_of(input int unsigned kernel);
    return kernel + 32'd1;
  endfunction

  function automatic int unsigned out_rows_of(input int unsigned img_rows, input int unsigned kernel);
    return img_rows - kernel + 32'd1;
  endfunction

  function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned nbuf);
    logic [31:0] v;
    v = 32'd0;
    if ((idx < nbuf) && (idx < 32'd32)) v[idx[4:0]] = 1'b1;
    else v = 32'd0;
    return v;
  endfunction

endpackage

// File: rtl/row_loader.sv
// Drains the FIFO into the ring of row buffers, never running more than one row ahead of the window.
module row_loader
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned ROW_WORDS = 4,
  parameter int unsigned KERNEL    = 3,
  parameter int unsigned IMG_ROWS  = 6,
  parameter int unsigned CW        = $clog2(IMG_ROWS + KERNEL + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       busy,
  input  logic [CW-1:0]              out_row,
  input  logic                       fifo_can_read,
  output logic                       fifo_rd_en,
  output logic [KERNEL:0]            row_wr_en,
  output logic [((ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1)-1:0] row_wr_addr,
  output logic                       row_full,
  output logic [CW-1:0]              rows_loaded
);

  localparam int unsigned NB = nbuf_of(KERNEL);
  localparam int unsigned SW = $clog2(NB);
  localparam int unsigned WW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [CW-1:0] IMG_C  = CW'(IMG_ROWS);
  localparam logic [CW-1:0] KER_C  = CW'(KERNEL);
  localparam logic [WW-1:0] LAST_W = WW'(ROW_WORDS - 1);
  localparam logic [SW-1:0] LAST_B = SW'(NB - 1);

  logic [WW-1:0] word_r;
  logic [SW-1:0] ld_buf_r;
  logic [CW-1:0] rows_r;
  logic          load_ok;
  logic [31:0]   oh;

  assign row_wr_addr = word_r;
  assign rows_loaded = rows_r;

  // Pop gating: the ring holds the window plus exactly one spare row.
  always_comb begin
    load_ok    = busy && (rows_r < IMG_C) && (rows_r <= out_row + KER_C);
    fifo_rd_en = load_ok && fifo_can_read;
    oh         = onehot(32'(ld_buf_r), NB);
    if (fifo_rd_en) row_wr_en = oh[NB-1:0];
    else row_wr_en = '0;
    row_full   = fifo_rd_en && (word_r == LAST_W);
  end

  // Word counter, fill buffer pointer and completed-row count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_r   <= '0;
      ld_buf_r <= '0;
      rows_r   <= '0;
    end else if (fifo_rd_en) begin
      if (word_r == LAST_W) begin
        word_r   <= '0;
        ld_buf_r <= (ld_buf_r == LAST_B) ? '0 : ld_buf_r + SW'(1);
        rows_r   <= rows_r + CW'(1);
      end else begin
        word_r   <= word_r + WW'(1);
      end
    end
  end

endmodule

// File: rtl/row_window_ctrl.sv
// Frame sequencer: DRAM read issue, row loading and one psum pass per resident K-row window.
module row_window_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned ROW_WORDS  = 4,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned IMG_ROWS   = 6,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned HEAD_W     = 6,
  parameter int unsigned ROW_STRIDE = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_W-1:0]                     cfg_base,
  input  logic                                  fifo_can_write,
  input  logic                                  fifo_can_read,
  output logic                                  dram_rd_en,
  output logic [ADDR_W-1:0]                     dram_rd_addr,
  output logic                                  fifo_rd_en,
  output logic [KERNEL:0]                       row_wr_en,
  output logic [((ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1)-1:0] row_wr_addr,
  output logic                                  row_full,
  output logic [$clog2(KERNEL+1)-1:0]           row_sel,
  output logic                                  psum_en,
  output logic                                  first,
  output logic                                  last,
  output logic [HEAD_W-1:0]                     head_addr,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned NB    = nbuf_of(KERNEL);
  localparam int unsigned SW    = $clog2(NB);
  localparam int unsigned CW    = $clog2(IMG_ROWS + KERNEL + 1);
  localparam int unsigned TOTAL = IMG_ROWS * ROW_WORDS;
  localparam int unsigned RW    = $clog2(TOTAL + 1);
  localparam int unsigned KW    = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam logic [RW-1:0]     TOTAL_C    = RW'(TOTAL);
  localparam logic [CW-1:0]     KER_C      = CW'(KERNEL);
  localparam logic [CW-1:0]     LAST_OUT_C = CW'(out_rows_of(IMG_ROWS, KERNEL) - 1);
  localparam logic [KW-1:0]     LAST_K     = KW'(KERNEL - 1);
  localparam logic [SW-1:0]     LAST_B     = SW'(NB - 1);
  localparam logic [HEAD_W-1:0] STRIDE_C   = HEAD_W'(ROW_STRIDE);

  ctrl_state_t       state_r, state_nx;
  logic [KW-1:0]     k_r, k_nx;
  logic [CW-1:0]     out_row_r;
  logic [CW-1:0]     rows_loaded;
  logic [RW-1:0]     rd_cnt_r;
  logic [HEAD_W-1:0] head_nx;
  logic              start_ok;

  assign start_ok   = start && (state_r == IDLE);
  assign dram_rd_en = busy && fifo_can_write && (rd_cnt_r < TOTAL_C);

  row_loader #(
    .ROW_WORDS (ROW_WORDS),
    .KERNEL    (KERNEL),
    .IMG_ROWS  (IMG_ROWS),
    .CW        (CW)
  ) u_loader (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_ok),
    .busy          (busy),
    .out_row       (out_row_r),
    .fifo_can_read (fifo_can_read),
    .fifo_rd_en    (fifo_rd_en),
    .row_wr_en     (row_wr_en),
    .row_wr_addr   (row_wr_addr),
    .row_full      (row_full),
    .rows_loaded   (rows_loaded)
  );

  // Next-state logic; the registered outputs are derived from the next state.
  always_comb begin
    state_nx = state_r;
    k_nx     = k_r;
    case (state_r)
      IDLE: begin
        if (start_ok) state_nx = WAIT;
        else state_nx = IDLE;
      end
      WAIT: begin
        if (rows_loaded >= out_row_r + KER_C) begin
          state_nx = RUN;
          k_nx     = '0;
        end else begin
          state_nx = WAIT;
        end
      end
      RUN: begin
        if (k_r == LAST_K) begin
          state_nx = ADV;
          k_nx     = '0;
        end else begin
          k_nx     = k_r + KW'(1);
        end
      end
      ADV: begin
        if (out_row_r == LAST_OUT_C) state_nx = DONE;
        else state_nx = WAIT;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == RUN) head_nx = HEAD_W'(k_nx) * STRIDE_C;
    else head_nx = '0;
  end

  // FSM state and psum-side outputs, so psum_en is high exactly in RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      k_r       <= '0;
      psum_en   <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      head_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nx;
      k_r       <= k_nx;
      psum_en   <= (state_nx == RUN);
      first     <= (state_nx == RUN) && (k_nx == KW'(0));
      last      <= (state_nx == RUN) && (k_nx == LAST_K);
      head_addr <= head_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
    end
  end

  // DRAM issue counter, window base and output-row count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_rd_addr <= '0;
      rd_cnt_r     <= '0;
      out_row_r    <= '0;
      row_sel      <= '0;
    end else if (start_ok) begin
      dram_rd_addr <= cfg_base;
      rd_cnt_r     <= '0;
      out_row_r    <= '0;
      row_sel      <= '0;
    end else begin
      if (dram_rd_en) begin
        dram_rd_addr <= dram_rd_addr + ADDR_W'(1);
        rd_cnt_r     <= rd_cnt_r + RW'(1);
      end
      if (state_r == ADV) begin
        row_sel   <= (row_sel == LAST_B) ? '0 : row_sel + SW'(1);
        out_row_r <= out_row_r + CW'(1);
      end
    end
  end

endmodule
